// File: rtl/hamming_universal_shift_reg4_if.sv
// Control, data and output bundle of the Hamming-protected 4-bit shift register.
// The master drives the controls and the slave drives the outputs.
interface hamming_universal_shift_reg4_if;
    logic       enable;
    logic [1:0] mode;
    logic       load;
    logic       serial_in;
    logic [3:0] parallel_in;
    logic       serial_out;
    logic [3:0] parallel_out;

    modport master (
        output enable, mode, load, serial_in, parallel_in,
        input  serial_out, parallel_out
    );

    modport slave (
        input  enable, mode, load, serial_in, parallel_in,
        output serial_out, parallel_out
    );
endinterface

// File: rtl/hamming_universal_shift_reg4.sv
// 4-bit universal shift register (SISO/SIPO/PISO/PIPO) stored as Hamming(7,4).
// The stored codeword is corrected on every read and re-encoded every cycle.
module hamming_universal_shift_reg4 (
    input  logic                          clk,
    input  logic                          rst,
    hamming_universal_shift_reg4_if.slave bus
);

    logic [6:0] reg_data;
    logic [6:0] reg_next;
    logic [6:0] fixed;
    logic [2:0] syn;
    logic [3:0] d;
    logic       load_sel;
    logic       shift_sel;

    // Codeword layout c6..c0 = d3 d2 d1 p4 d0 p2 p1
    function automatic logic [6:0] enc(input logic [3:0] v);
        return {v[3], v[2], v[1],
                v[1] ^ v[2] ^ v[3],
                v[0],
                v[0] ^ v[2] ^ v[3],
                v[0] ^ v[1] ^ v[3]};
    endfunction

    always_comb begin
        syn[0] = reg_data[0] ^ reg_data[2] ^ reg_data[4] ^ reg_data[6];
        syn[1] = reg_data[1] ^ reg_data[2] ^ reg_data[5] ^ reg_data[6];
        syn[2] = reg_data[3] ^ reg_data[4] ^ reg_data[5] ^ reg_data[6];
        fixed  = reg_data;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~reg_data[syn - 3'd1];
        end
        d = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

    assign load_sel  = bus.load & bus.mode[1];
    assign shift_sel = bus.enable & (bus.mode != 2'b11);

    always_comb begin
        reg_next = enc(d);
        if (load_sel) begin
            reg_next = enc(bus.parallel_in);
        end else if (shift_sel) begin
            reg_next = enc({d[2:0], bus.serial_in});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_data <= 7'b0000000;
        end else begin
            reg_data <= reg_next;
        end
    end

    // Modes 00/10 expose the serial tap, modes 01/11 the parallel word
    assign bus.serial_out   = bus.mode[0] ? 1'b0 : d[3];
    assign bus.parallel_out = bus.mode[0] ? d : 4'b0000;

endmodule

// File: tb/tb_hamming_universal_shift_reg4.sv
// Randomised scoreboard bench for the Hamming-protected shift register.
// A word-level model predicts outputs; a monitor pops and compares them.
module tb_hamming_universal_shift_reg4;

    logic clk;
    logic rst;
    hamming_universal_shift_reg4_if bus ();

    hamming_universal_shift_reg4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [3:0] model;
    logic [4:0] exp_q [$];
    bit         mon_on;

    // Hamming(7,4) from positions: data at 3,5,6,7; parity k covers positions with bit k set
    function automatic logic [6:0] ham(input logic [3:0] v);
        logic [7:1] c;
        int dp [4];
        dp = '{3, 5, 6, 7};
        c = '0;
        for (int i = 0; i < 4; i++) c[dp[i]] = v[i];
        for (int k = 0; k < 3; k++)
            for (int p = 1; p <= 7; p++)
                if (((p >> k) & 1) == 1 && p != (1 << k))
                    c[1 << k] = c[1 << k] ^ c[p];
        return c;
    endfunction

    // Monitor: outputs are combinational, so each cycle presents one result
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_on && exp_q.size() > 0) begin
                logic [4:0] e;
                e = exp_q.pop_front();
                checks++;
                if (bus.serial_out !== e[4]) begin
                    errors++;
                    $display("FAIL serial_out got %b want %b at %0t",
                             bus.serial_out, e[4], $time);
                end
                checks++;
                if (bus.parallel_out !== e[3:0]) begin
                    errors++;
                    $display("FAIL parallel_out got %b want %b at %0t",
                             bus.parallel_out, e[3:0], $time);
                end
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic [1:0] m,
                        input logic ld, input logic si, input logic [3:0] pi,
                        input logic [6:0] flip);
        logic [4:0] e;
        logic [6:0] want;
        @(negedge clk);
        rst = r;
        bus.enable = en;
        bus.mode = m;
        bus.load = ld;
        bus.serial_in = si;
        bus.parallel_in = pi;
        if (flip != 7'd0) force dut.reg_data = ham(model) ^ flip;
        e[4] = (m == 2'b00 || m == 2'b10) ? model[3] : 1'b0;
        e[3:0] = (m == 2'b01 || m == 2'b11) ? model : 4'b0000;
        exp_q.push_back(e);
        #3;
        if (flip != 7'd0) release dut.reg_data;
        if (r) model = 4'd0;
        else if (ld && (m == 2'b10 || m == 2'b11)) model = pi;
        else if (en && m != 2'b11) model = {model[2:0], si};
        @(posedge clk);
        #1;
        want = ham(model);
        checks++;
        if (dut.reg_data !== want) begin
            errors++;
            $display("FAIL reg_data got %b want %b at %0t",
                     dut.reg_data, want, $time);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model = 4'd0;
        mon_on = 1'b0;
        rst = 1'b1;
        bus.enable = 1'b1;
        bus.mode = 2'b10;
        bus.load = 1'b1;
        bus.serial_in = 1'b1;
        bus.parallel_in = 4'hF;
        @(posedge clk);
        #1;
        checks++;
        if (dut.reg_data !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_reg got %b want 0000000", dut.reg_data);
        end
        mon_on = 1'b1;

        // SISO: 1,0,0,0 then the 1 reaches serial_out
        step(0, 1, 2'b00, 0, 1, 4'h0, 7'd0);
        step(0, 1, 2'b00, 0, 0, 4'h0, 7'd0);
        step(0, 1, 2'b00, 0, 0, 4'h0, 7'd0);
        step(0, 1, 2'b00, 0, 0, 4'h0, 7'd0);
        step(0, 0, 2'b00, 0, 0, 4'h0, 7'd0);
        // SIPO after reset, then hold
        step(1, 0, 2'b01, 0, 0, 4'h0, 7'd0);
        step(0, 1, 2'b01, 0, 1, 4'h0, 7'd0);
        step(0, 1, 2'b01, 0, 1, 4'h0, 7'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 2'b01, 0, 1, 4'h0, 7'd0);
        // PISO load 1011 then shift zeros
        step(0, 0, 2'b10, 1, 0, 4'b1011, 7'd0);
        for (int i = 0; i < 5; i++) step(0, 1, 2'b10, 0, 0, 4'h0, 7'd0);
        // PIPO load 1101; enable ignored
        step(0, 0, 2'b11, 1, 0, 4'b1101, 7'd0);
        step(0, 1, 2'b11, 0, 1, 4'h0, 7'd0);
        // SEU on held 1011
        step(0, 0, 2'b11, 1, 0, 4'b1011, 7'd0);
        step(0, 0, 2'b11, 0, 0, 4'h0, 7'b0001000);
        step(0, 0, 2'b11, 0, 0, 4'h0, 7'b1000000);
        step(0, 1, 2'b11, 0, 0, 4'h0, 7'b0000001);
        // Priority: reset beats load; load ignored in mode 00
        step(1, 1, 2'b11, 1, 1, 4'hF, 7'd0);
        step(0, 1, 2'b00, 1, 1, 4'hA, 7'd0);
        step(0, 1, 2'b01, 1, 0, 4'h5, 7'd0);
        step(0, 0, 2'b01, 0, 0, 4'h0, 7'd0);

        for (int i = 0; i < 400; i++) begin
            logic [6:0] f;
            f = ($urandom_range(0, 4) == 0) ?
                7'(1 << $urandom_range(0, 6)) : 7'd0;
            step(($urandom_range(0, 29) == 0),
                 1'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), 4'($urandom), f);
        end

        @(negedge clk);
        #4;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
